// File: rtl/fp2_sub_serial_if.sv
// Request/response bundle for the serial Fp2 subtractor: operands and start in,
// busy/done and the two result halves out.
interface fp2_sub_serial_if;
  // Handshake: start is a one-cycle request taken only while the block is idle
  // (busy=0); done pulses for exactly one cycle when D1/D2 hold the new result,
  // and busy stays high from the cycle after acceptance through that done cycle.
  logic         start;
  logic [254:0] A1;
  logic [254:0] B1;
  logic [254:0] A2;
  logic [254:0] B2;
  logic         busy;
  logic         done;
  logic [254:0] D1;
  logic [254:0] D2;

  modport master (
    output start, A1, B1, A2, B2,
    input  busy, done, D1, D2
  );

  modport slave (
    input  start, A1, B1, A2, B2,
    output busy, done, D1, D2
  );
endinterface

// File: rtl/fp2_sub_serial.sv
// Serial Fp2 subtraction (X - Y) mod P through one LIMB_W-bit subtract/add datapath,
// real part first, then imaginary part, each as a borrow pass plus a correction pass.
module fp2_sub_serial #(
  parameter logic [254:0] P      = (255'd5 << 248) - 255'd1,
  parameter int           LIMB_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  fp2_sub_serial_if.slave       bus,
  output logic [2:0]            dbg_state
);

  localparam int NLIMB = 256 / LIMB_W;
  localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NLIMB - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUB_RE = 3'd1,
    COR_RE = 3'd2,
    SUB_IM = 3'd3,
    COR_IM = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              flag_q;
  logic              chain_q;
  logic              wb_q;
  logic [255:0]      a1_q, a2_q, b1_q, b2_q;
  logic [255:0]      diff_re_q, diff_im_q;
  logic [254:0]      d1_q, d2_q;

  logic [255:0]      p_ext;
  logic [LIMB_W-1:0] x_limb, y_limb, r_limb;
  logic [LIMB_W:0]   sum;
  logic              is_sub, active, cin, cout;
  logic              busy_c, done_c;
  int                base;

  assign p_ext = {1'b0, P};
  assign base  = int'(cnt_q) * LIMB_W;

  // One shared limb datapath; the state picks operands and whether it subtracts or adds.
  always_comb begin
    x_limb = '0;
    y_limb = '0;
    is_sub = 1'b0;
    active = 1'b0;
    case (state_q)
      SUB_RE: begin
        x_limb = a1_q[base +: LIMB_W];
        y_limb = a2_q[base +: LIMB_W];
        is_sub = 1'b1;
        active = 1'b1;
      end
      COR_RE: begin
        x_limb = diff_re_q[base +: LIMB_W];
        y_limb = flag_q ? p_ext[base +: LIMB_W] : '0;
        active = 1'b1;
      end
      SUB_IM: begin
        x_limb = b1_q[base +: LIMB_W];
        y_limb = b2_q[base +: LIMB_W];
        is_sub = 1'b1;
        active = 1'b1;
      end
      COR_IM: begin
        x_limb = diff_im_q[base +: LIMB_W];
        y_limb = flag_q ? p_ext[base +: LIMB_W] : '0;
        active = !wb_q;
      end
      default: ;
    endcase
    cin = (cnt_q == '0) ? 1'b0 : chain_q;
    if (is_sub)
      sum = {1'b0, x_limb} - {1'b0, y_limb} - (LIMB_W + 1)'(cin);
    else
      sum = {1'b0, x_limb} + {1'b0, y_limb} + (LIMB_W + 1)'(cin);
    r_limb = sum[LIMB_W-1:0];
    cout   = sum[LIMB_W];
  end

  // COR_IM lingers one cycle after its last limb (wb_q) so the finished results
  // are committed to D1/D2 on the same edge that enters DONE.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE:   if (bus.start) state_d = SUB_RE;
      SUB_RE: begin busy_c = 1'b1; if (cnt_q == LAST) state_d = COR_RE; end
      COR_RE: begin busy_c = 1'b1; if (cnt_q == LAST) state_d = SUB_IM; end
      SUB_IM: begin busy_c = 1'b1; if (cnt_q == LAST) state_d = COR_IM; end
      COR_IM: begin busy_c = 1'b1; if (wb_q) state_d = DONE; end
      DONE:   begin busy_c = 1'b1; done_c = 1'b1; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flag_q    <= 1'b0;
      chain_q   <= 1'b0;
      wb_q      <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      diff_re_q <= '0;
      diff_im_q <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start) begin
        a1_q    <= {1'b0, bus.A1};
        a2_q    <= {1'b0, bus.A2};
        b1_q    <= {1'b0, bus.B1};
        b2_q    <= {1'b0, bus.B2};
        cnt_q   <= '0;
        flag_q  <= 1'b0;
        chain_q <= 1'b0;
        wb_q    <= 1'b0;
      end
      if (active) begin
        cnt_q   <= cnt_q + 1'b1;
        chain_q <= cout;
        if (state_q == SUB_RE || state_q == COR_RE)
          diff_re_q[base +: LIMB_W] <= r_limb;
        else
          diff_im_q[base +: LIMB_W] <= r_limb;
        // The borrow out of the top limb says the raw difference went negative.
        if (is_sub && cnt_q == LAST)
          flag_q <= cout;
        if (state_q == COR_IM && cnt_q == LAST)
          wb_q <= 1'b1;
      end
      if (state_q == COR_IM && wb_q) begin
        d1_q <= diff_re_q[254:0];
        d2_q <= diff_im_q[254:0];
        wb_q <= 1'b0;
      end
    end
  end

  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.D1    = d1_q;
  assign bus.D2    = d2_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fp2_sub_serial.md
FP2_SUB_SERIAL -- requirements
Module: fp2_sub_serial

Interface
REQ-001: Parameter P, default 255'h04FF_FFFF_..._FFFF (5*2^248-1), the field prime for all reductions.
REQ-002: Parameter LIMB_W, default 64, the width of the serial subtract/add datapath; 256/LIMB_W limbs per operand.
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: start  input  1  request strobe; sampled only in IDLE.
REQ-006: A1, B1  input  255 each  real and imaginary parts of minuend X = A1 + B1*i.
REQ-007: A2, B2  input  255 each  real and imaginary parts of subtrahend Y = A2 + B2*i.
REQ-008: busy  output  1  high from the cycle after start is accepted until done deasserts.
REQ-009: done  output  1  single-cycle completion pulse.
REQ-010: D1, D2  output  255 each  results: D1 = (A1-A2) mod P, D2 = (B1-B2) mod P.

Function
REQ-011: Operands are captured into internal registers on the edge where start=1 in IDLE; input changes afterwards do not affect the result.
REQ-012: Operands are zero-extended to 256 bits and processed least-significant limb first.
REQ-013: FSM states: IDLE, SUB_RE, COR_RE, SUB_IM, COR_IM, DONE; a 2-bit limb counter indexes limbs in every non-IDLE/DONE state.
REQ-014: SUB_RE: one limb of A1-A2 per cycle with borrow chain (borrow-in 0 on limb 0); after limb 3, the final borrow is latched as the correction flag.
REQ-015: COR_RE: one limb per cycle adds (flag ? P : 0) to the difference with carry chain (carry-in 0 on limb 0); the carry out of limb 3 is discarded.
REQ-016: SUB_IM and COR_IM repeat REQ-014/015 on B1-B2 using the same single LIMB_W datapath.
REQ-017: Correction always runs 4 cycles regardless of flag; latency is fixed.
REQ-018: Transition IDLE->SUB_RE on accepted start; each compute state advances after limb counter 3; COR_IM->DONE; DONE->IDLE unconditionally.
REQ-019: Latency: start sampled at edge 0 -> done high in the cycle following edge 17, low after edge 18; D1/D2 updated at edge 17.
REQ-020: D1/D2 hold their value from one completion until the next completion or reset; intermediate limb results are never visible on D1/D2.
REQ-021: start is ignored in every state other than IDLE, including DONE; no queuing.
REQ-022: Inputs are required to lie in [0, P); for such inputs outputs lie in [0, P). Behaviour for unreduced inputs is the raw 256-bit result truncated to 255 bits, not checked.
REQ-023: busy = 1 in SUB_RE, COR_RE, SUB_IM, COR_IM, DONE; done = 1 only in DONE.

Reset
REQ-024: rst=1 forces state IDLE, limb counter 0, correction flag 0, busy=0, done=0, D1=0, D2=0, operand registers 0, asynchronously.
REQ-025: rst asserted mid-operation aborts it; no done pulse is produced for the aborted request, and the first start after rst releases is processed normally.

Verification
REQ-026: A1=3,A2=1,B1=0,B2=0, start -> done at cycle 18, D1=2, D2=0, busy high cycles 1..18.
REQ-027: A1=1,A2=3,B1=0,B2=P-1 -> D1=P-2, D2=1 (both correction paths taken).
REQ-028: A1=P-1,A2=0,B1=P-1,B2=P-1 -> D1=P-1, D2=0; limb-boundary values A1=2^64,A2=1 -> D1=2^64-1 (borrow across limb 0/1).
REQ-029: start pulsed again at cycles 5 and 18 with different operands -> ignored; exactly one done, results from the first request only.
REQ-030: rst asserted at cycle 9 of a request -> busy/done/D1/D2 zero immediately, no done afterwards; new start after release -> correct result at 17 cycles latency.
REQ-031: Random reduced operands (>=10k vectors, back-to-back starts in the cycle after done) checked against a software mod-P reference; input bus toggled during busy without effect.
